input_acc_sched: RTL and testbench

INPUT_ACC_SCHED -- requirements
Module: input_acc_sched

---
 rtl/input_acc_pkg.sv | 12 +
 rtl/input_acc_sched_if.sv | 37 +++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/input_acc_sched.sv | 113 +++++++++++
 tb/tb_input_acc_sched.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/input_acc_pkg.sv
// Shared types for the input-accumulator scheduler: data width, sample type and FSM state encoding.
package input_acc_pkg;
  localparam int DATA_WIDTH = 16;

  typedef logic signed [DATA_WIDTH-1:0] acc_data_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } input_acc_sched_state_t;
endpackage

// File: rtl/input_acc_sched_if.sv
// Host/NN enqueue handshakes, drain control and accumulator-facing strobes of input_acc_sched.
// The slave modport is the scheduler side; the master modport is the requester/observer side.
interface input_acc_sched_if #(
  parameter int DEPTH = 4
);
  import input_acc_pkg::*;

  logic                       host_valid_in;
  acc_data_t                  host_data_in;
  logic                       host_ready_out;
  logic                       nn_valid_in;
  acc_data_t                  nn_data_in;
  logic                       nn_ready_out;
  logic                       drain_start_in;
  logic                       acc_valid_data_out;
  acc_data_t                  acc_data_out;
  logic                       acc_valid_data_nn_out;
  acc_data_t                  acc_data_nn_out;
  logic                       acc_valid_out;
  logic [$clog2(DEPTH+1)-1:0] occupancy_out;
  logic                       busy_out;
  logic                       done_out;

  modport slave (
    input  host_valid_in, host_data_in, nn_valid_in, nn_data_in, drain_start_in,
    output host_ready_out, nn_ready_out, acc_valid_data_out, acc_data_out,
           acc_valid_data_nn_out, acc_data_nn_out, acc_valid_out,
           occupancy_out, busy_out, done_out
  );

  modport master (
    output host_valid_in, host_data_in, nn_valid_in, nn_data_in, drain_start_in,
    input  host_ready_out, nn_ready_out, acc_valid_data_out, acc_data_out,
           acc_valid_data_nn_out, acc_data_nn_out, acc_valid_out,
           occupancy_out, busy_out, done_out
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester grant (req[0]=host, req[1]=NN), combinational grant, pointer moves on advance.
// INPUT_ACC_SCHED_RR_EN selects round-robin; otherwise fixed priority with req[1] winning.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
`ifdef INPUT_ACC_SCHED_RR_EN
  logic r_ptr; // 0: host preferred, 1: NN preferred

  always_comb begin
    grant = 2'b00;
    if (!r_ptr) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  // after a host win prefer NN next, and vice versa
  always_ff @(posedge clk) begin
    if (rst)          r_ptr <= 1'b0;
    else if (advance) r_ptr <= grant[0];
  end
`else
  logic w_unused;

  assign grant    = {req[1], req[0] & ~req[1]};
  assign w_unused = &{1'b0, clk, rst, advance};
`endif
endmodule

// File: rtl/input_acc_sched.sv
// Schedules host/NN enqueues into a DEPTH-entry accumulator and drains it on request (FILL/DRAIN/DONE).
// Enqueue strobes follow the accept by one cycle; readies are low when full or not in FILL.
module input_acc_sched
  import input_acc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input_acc_sched_if.slave    bus
);
  localparam int              OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  input_acc_sched_state_t r_state;
  logic [OCC_W-1:0]       r_occ;
  logic                   r_acc_vld;
  logic                   r_acc_vld_nn;
  logic                   r_deq;
  logic                   r_done;
  logic                   r_busy;
  acc_data_t              r_acc_dat;
  acc_data_t              r_acc_dat_nn;

  logic [1:0]             w_grant;
  logic                   w_open;
  logic                   w_acc_host;
  logic                   w_acc_nn;

  assign w_open     = (r_state == ST_FILL) && (r_occ < OCC_MAX);
  assign w_acc_host = w_open & w_grant[0];
  assign w_acc_nn   = w_open & w_grant[1];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.nn_valid_in, bus.host_valid_in}),
    .advance (w_acc_host | w_acc_nn),
    .grant   (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FILL;
      r_occ        <= '0;
      r_acc_vld    <= 1'b0;
      r_acc_vld_nn <= 1'b0;
      r_deq        <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_acc_dat    <= '0;
      r_acc_dat_nn <= '0;
    end else begin
      r_acc_vld    <= 1'b0;
      r_acc_vld_nn <= 1'b0;
      r_deq        <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_acc_host) begin
            r_acc_vld <= 1'b1;
            r_acc_dat <= bus.host_data_in;
            r_occ     <= r_occ + OCC_ONE;
          end else if (w_acc_nn) begin
            r_acc_vld_nn <= 1'b1;
            r_acc_dat_nn <= bus.nn_data_in;
            r_occ        <= r_occ + OCC_ONE;
          end
          // an empty drain still reports completion through DONE
          if (bus.drain_start_in) begin
            r_busy <= 1'b1;
            if (r_occ != '0) begin
              r_state <= ST_DRAIN;
              r_deq   <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_occ <= r_occ - OCC_ONE;
          if (r_occ == OCC_ONE) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_deq <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_FILL;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_FILL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.host_ready_out        = w_acc_host;
  assign bus.nn_ready_out          = w_acc_nn;
  assign bus.acc_valid_data_out    = r_acc_vld;
  assign bus.acc_data_out          = r_acc_dat;
  assign bus.acc_valid_data_nn_out = r_acc_vld_nn;
  assign bus.acc_data_nn_out       = r_acc_dat_nn;
  assign bus.acc_valid_out         = r_deq;
  assign bus.occupancy_out         = r_occ;
  assign bus.busy_out              = r_busy;
  assign bus.done_out              = r_done;
endmodule

// File: tb/tb_input_acc_sched.sv
// Bench for input_acc_sched: per-cycle vector table plus scoreboard of enqueue strobes.
// Arbitration expectations follow INPUT_ACC_SCHED_RR_EN when it is defined.
module tb_input_acc_sched;
  import input_acc_pkg::*;

  localparam int DEPTH = 4;
`ifdef INPUT_ACC_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_acc_sched_if #(.DEPTH(DEPTH)) bus ();

  input_acc_sched #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic      hv;
    acc_data_t hd;
    logic      nv;
    acc_data_t nd;
    logic      ds;
    logic      rs;
    logic      e_hr;
    logic      e_nr;
    int        e_occ;
    logic      e_busy;
    logic      e_done;
    logic      e_deq;
  } vec_t;

  typedef struct {
    logic nn;
    int   dat;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[$];
  int   n_chk;
  int   n_fail;
  logic exp_sh;
  logic exp_sn;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic hv, input int hd, input logic nv, input int nd,
                              input logic ds, input logic ehr, input logic enr, input int eocc,
                              input logic eb, input logic ed, input logic eq);
    vec_t v;
    v.hv = hv; v.hd = hd[15:0]; v.nv = nv; v.nd = nd[15:0]; v.ds = ds; v.rs = 1'b0;
    v.e_hr = ehr; v.e_nr = enr; v.e_occ = eocc; v.e_busy = eb; v.e_done = ed; v.e_deq = eq;
    return v;
  endfunction

  // drive one cycle at posedge+1, sample at posedge+2, return at next posedge+1
  task automatic apply(input vec_t v, input int idx);
    sb_t e;
    bus.host_valid_in  = v.hv;
    bus.host_data_in   = v.hd;
    bus.nn_valid_in    = v.nv;
    bus.nn_data_in     = v.nd;
    bus.drain_start_in = v.ds;
    rst                = v.rs;
    #1;
    chk("host_ready", idx, int'(bus.host_ready_out), int'(v.e_hr));
    chk("nn_ready", idx, int'(bus.nn_ready_out), int'(v.e_nr));
    chk("occupancy", idx, int'(bus.occupancy_out), v.e_occ);
    chk("busy", idx, int'(bus.busy_out), int'(v.e_busy));
    chk("done", idx, int'(bus.done_out), int'(v.e_done));
    chk("acc_valid", idx, int'(bus.acc_valid_out), int'(v.e_deq));
    chk("host_strobe", idx, int'(bus.acc_valid_data_out), int'(exp_sh));
    chk("nn_strobe", idx, int'(bus.acc_valid_data_nn_out), int'(exp_sn));
    chk("strobe_overlap", idx, int'(bus.acc_valid_data_out & bus.acc_valid_data_nn_out), 0);
    if (bus.acc_valid_data_out || bus.acc_valid_data_nn_out) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard at step %0d: strobe with no pending accept", idx);
      end else begin
        e = sbq.pop_front();
        chk("strobe_path", idx, int'(bus.acc_valid_data_nn_out), int'(e.nn));
        chk("strobe_data", idx,
            bus.acc_valid_data_nn_out ? int'(bus.acc_data_nn_out) : int'(bus.acc_data_out), e.dat);
      end
    end
    if (v.rs) sbq.delete();
    exp_sh = v.hv & v.e_hr & ~v.rs;
    exp_sn = v.nv & v.e_nr & ~v.rs;
    if (exp_sh) sbq.push_back('{1'b0, int'(v.hd)});
    if (exp_sn) sbq.push_back('{1'b1, int'(v.nd)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    n_chk  = 0;
    n_fail = 0;
    exp_sh = 1'b0;
    exp_sn = 1'b0;
    rst    = 1'b1;
    bus.host_valid_in  = 1'b0;
    bus.host_data_in   = '0;
    bus.nn_valid_in    = 1'b0;
    bus.nn_data_in     = '0;
    bus.drain_start_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occupancy", -1, int'(bus.occupancy_out), 0);
    chk("rst_busy", -1, int'(bus.busy_out), 0);
    chk("rst_done", -1, int'(bus.done_out), 0);
    chk("rst_acc_valid", -1, int'(bus.acc_valid_out), 0);
    chk("rst_host_strobe", -1, int'(bus.acc_valid_data_out), 0);
    chk("rst_nn_strobe", -1, int'(bus.acc_valid_data_nn_out), 0);
    chk("rst_host_data", -1, int'(bus.acc_data_out), 0);
    chk("rst_nn_data", -1, int'(bus.acc_data_nn_out), 0);

    //                 hv  hd   nv  nd  ds  hr nr occ bsy dn deq
    tbl.push_back(mk(1, 10,  0, 0,  0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 20,  0, 0,  0,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 30,  0, 0,  0,  1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 40,  0, 0,  0,  1, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 50,  0, 0,  0,  0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 0,   1, 7,  0,  0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,  1,  0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(1, 9,   0, 0,  1,  0, 0, 4, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 3, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 9,   0, 0,  0,  0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, -5,  0, 0,  0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   1, 100, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 300, 0, 0,  0,  1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,  1,  0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 3, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0,   0, 0,  1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1,   0, 0,  0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2,   0, 0,  1,  1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 2, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0,   0, 0,  0,  0, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // reset so the round-robin pointer starts on the host again
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rs = 1'b1;
    apply(v, 100);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 101);

    // both requesters continuously valid until the accumulator fills
    for (int k = 0; k <= DEPTH; k++) begin
      logic eh;
      logic en;
      eh = (k < DEPTH) && (RR ? (k % 2 == 0) : 1'b0);
      en = (k < DEPTH) && (RR ? (k % 2 == 1) : 1'b1);
      apply(mk(1, 1, 1, 2, 0, eh, en, k, 0, 0, 0), 200 + k);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, DEPTH, 0, 0, 0), 210);

    // reset on the second drain cycle aborts the drain
    apply(mk(0, 0, 0, 0, 1, 0, 0, DEPTH, 0, 0, 0), 300);
    apply(mk(0, 0, 0, 0, 0, 0, 0, DEPTH, 1, 0, 1), 301);
    v = mk(0, 0, 0, 0, 0, 0, 0, DEPTH - 1, 1, 0, 1);
    v.rs = 1'b1;
    apply(v, 302);
    for (int k = 0; k < 3; k++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 303 + k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
